// File: rtl/rc4_encrypt.sv
// rc4_encrypt: RC4 encryptor for a 24-bit key.
//   Builds the RC4 permutation in an external S RAM (identity fill, then KSA),
//   runs MSG_LEN PRGA steps and writes C[k] = P[k] ^ keystream[k] to the
//   ciphertext RAM.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   start_i, secret_key_i 1-cycle request; key {K0,K1,K2} latched with it
//   s_addr_o/s_wdata_o/s_we_o/s_q_i   S RAM (registered read, 2-cycle latency)
//   p_addr_o/p_q_i                    plaintext ROM (registered read)
//   c_addr_o/c_wdata_o/c_we_o         ciphertext RAM
//   busy_o, done_o                    status
// All RAM-side outputs are registered.
module rc4_encrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [23:0] secret_key_i,
  output logic [7:0]  s_addr_o,
  output logic [7:0]  s_wdata_o,
  output logic        s_we_o,
  input  logic [7:0]  s_q_i,
  output logic [7:0]  p_addr_o,
  input  logic [7:0]  p_q_i,
  output logic [7:0]  c_addr_o,
  output logic [7:0]  c_wdata_o,
  output logic        c_we_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RDI, K_WI, K_LI, K_RDJ, K_WJ, K_LJ, K_WRJ, K_WRI,
    P_INC, P_RDI, P_WI, P_LI, P_RDJ, P_WJ, P_LJ, P_WRJ, P_WRI,
    P_RDF, P_WF, P_LF,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [7:0]  si_q, si_d, sj_q, sj_d;
  logic [7:0]  s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic        s_we_q, s_we_d;
  logic [7:0]  p_addr_q, p_addr_d;
  logic [7:0]  c_addr_q, c_addr_d, c_wdata_q, c_wdata_d;
  logic        c_we_q, c_we_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [7:0]  key_byte;

  // Key byte for the current KSA step; kidx tracks i mod 3 without a divider.
  always_comb begin
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    kidx_d    = kidx_q;
    si_d      = si_q;
    sj_d      = sj_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = 1'b0;
    p_addr_d  = p_addr_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_we_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        if (start_i) begin
          key_d   = secret_key_i;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          kidx_d  = 2'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        s_we_d    = 1'b1;
        s_addr_d  = i_q;
        s_wdata_d = i_q;
        i_d       = i_q + 8'd1;      // wraps to 0 after 255
        if (i_q == 8'hFF) state_d = K_RDI;
      end
      K_RDI: begin s_addr_d = i_q; state_d = K_WI; end
      K_WI:  state_d = K_LI;
      K_LI: begin
        si_d    = s_q_i;
        j_d     = j_q + s_q_i + key_byte;
        state_d = K_RDJ;
      end
      K_RDJ: begin s_addr_d = j_q; state_d = K_WJ; end
      K_WJ:  state_d = K_LJ;
      K_LJ:  begin sj_d = s_q_i; state_d = K_WRJ; end
      K_WRJ: begin
        s_we_d = 1'b1; s_addr_d = j_q; s_wdata_d = si_q;
        state_d = K_WRI;
      end
      K_WRI: begin
        s_we_d = 1'b1; s_addr_d = i_q; s_wdata_d = sj_q;
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
        if (i_q == 8'hFF) begin
          j_d     = 8'd0;
          state_d = P_INC;
        end else begin
          state_d = K_RDI;
        end
      end
      P_INC: begin i_d = i_q + 8'd1; state_d = P_RDI; end
      P_RDI: begin s_addr_d = i_q; state_d = P_WI; end
      P_WI:  state_d = P_LI;
      P_LI: begin
        si_d    = s_q_i;
        j_d     = j_q + s_q_i;
        state_d = P_RDJ;
      end
      P_RDJ: begin s_addr_d = j_q; state_d = P_WJ; end
      P_WJ:  state_d = P_LJ;
      P_LJ:  begin sj_d = s_q_i; state_d = P_WRJ; end
      P_WRJ: begin
        s_we_d = 1'b1; s_addr_d = j_q; s_wdata_d = si_q;
        state_d = P_WRI;
      end
      P_WRI: begin
        s_we_d = 1'b1; s_addr_d = i_q; s_wdata_d = sj_q;
        state_d = P_RDF;
      end
      // si+sj taken from the pre-swap values equals S[i]+S[j] after the swap.
      P_RDF: begin
        s_addr_d = si_q + sj_q;
        p_addr_d = k_q;
        state_d  = P_WF;
      end
      P_WF: state_d = P_LF;
      P_LF: begin
        c_we_d    = 1'b1;
        c_addr_d  = k_q;
        c_wdata_d = s_q_i ^ p_q_i;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = P_INC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      key_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      kidx_q    <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      p_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      c_we_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      kidx_q    <= kidx_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_we_q    <= s_we_d;
      p_addr_q  <= p_addr_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_we_q    <= c_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_we_o    = s_we_q;
  assign p_addr_o  = p_addr_q;
  assign c_addr_o  = c_addr_q;
  assign c_wdata_o = c_wdata_q;
  assign c_we_o    = c_we_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_rc4_encrypt.sv
// Testbench for rc4_encrypt: two instances (MSG_LEN 9 and 32), each with its
// own S RAM, plaintext ROM and ciphertext RAM models, a write monitor and an
// RC4 reference model for expected keystreams.
module tb_rc4_encrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        start9 = 1'b0, start32 = 1'b0;
  logic [23:0] key9 = '0, key32 = '0;

  logic [7:0] s_addr9, s_wdata9, s_q9, p_addr9, p_q9, c_addr9, c_wdata9;
  logic       s_we9, c_we9, busy9, done9;
  logic [7:0] s_addr32, s_wdata32, s_q32, p_addr32, p_q32, c_addr32, c_wdata32;
  logic       s_we32, c_we32, busy32, done32;

  logic [7:0] s_mem9[256], p_mem9[256], c_mem9[256];
  logic [7:0] s_mem32[256], p_mem32[256], c_mem32[256];
  logic [7:0] ref_s[256], ref_ks[256];

  int checks = 0, errors = 0;
  int swr9 = 0, cwr9 = 0, both9 = 0, cbad9 = 0;
  int swr32 = 0, cwr32 = 0, both32 = 0, cbad32 = 0;
  logic [255:0] cmask9 = '0, cmask32 = '0;

  rc4_encrypt #(.MSG_LEN(9)) dut9 (
    .clk_i(clk), .reset_i(rst), .start_i(start9), .secret_key_i(key9),
    .s_addr_o(s_addr9), .s_wdata_o(s_wdata9), .s_we_o(s_we9), .s_q_i(s_q9),
    .p_addr_o(p_addr9), .p_q_i(p_q9),
    .c_addr_o(c_addr9), .c_wdata_o(c_wdata9), .c_we_o(c_we9),
    .busy_o(busy9), .done_o(done9)
  );

  rc4_encrypt #(.MSG_LEN(32)) dut32 (
    .clk_i(clk), .reset_i(rst), .start_i(start32), .secret_key_i(key32),
    .s_addr_o(s_addr32), .s_wdata_o(s_wdata32), .s_we_o(s_we32), .s_q_i(s_q32),
    .p_addr_o(p_addr32), .p_q_i(p_q32),
    .c_addr_o(c_addr32), .c_wdata_o(c_wdata32), .c_we_o(c_we32),
    .busy_o(busy32), .done_o(done32)
  );

  // Memory models: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (s_we9) s_mem9[s_addr9] <= s_wdata9;
    s_q9 <= s_mem9[s_addr9];
    p_q9 <= p_mem9[p_addr9];
    if (clr) begin
      for (int a = 0; a < 256; a++) c_mem9[a] <= 8'hEE;
    end else if (c_we9) begin
      c_mem9[c_addr9] <= c_wdata9;
    end
  end

  always @(posedge clk) begin
    if (s_we32) s_mem32[s_addr32] <= s_wdata32;
    s_q32 <= s_mem32[s_addr32];
    p_q32 <= p_mem32[p_addr32];
    if (clr) begin
      for (int b = 0; b < 256; b++) c_mem32[b] <= 8'hEE;
    end else if (c_we32) begin
      c_mem32[c_addr32] <= c_wdata32;
    end
  end

  // Write monitors
  always @(negedge clk) begin
    if (clr) begin
      swr9 = 0; cwr9 = 0; both9 = 0; cbad9 = 0; cmask9 = '0;
      swr32 = 0; cwr32 = 0; both32 = 0; cbad32 = 0; cmask32 = '0;
    end else begin
      if (s_we9 && c_we9) both9++;
      if (s_we9) swr9++;
      if (c_we9) begin
        cwr9++;
        if (c_addr9 < 8'd9) cmask9[c_addr9] = 1'b1; else cbad9++;
      end
      if (s_we32 && c_we32) both32++;
      if (s_we32) swr32++;
      if (c_we32) begin
        cwr32++;
        if (c_addr32 < 8'd32) cmask32[c_addr32] = 1'b1; else cbad32++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // RC4 reference: fills ref_s (final state) and ref_ks[0..n-1].
  task automatic rc4_model(input logic [23:0] key, input int n);
    logic [7:0] kb[3];
    logic [7:0] t, i, j;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + ref_s[a] + kb[a % 3];
      t = ref_s[a]; ref_s[a] = ref_s[j]; ref_s[j] = t;
    end
    i = 8'd0; j = 8'd0;
    for (int k = 0; k < n; k++) begin
      i = i + 8'd1;
      j = j + ref_s[i];
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      ref_ks[k] = ref_s[8'(ref_s[i] + ref_s[j])];
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  // mode 0: plain run; 1: extra start pulses in KSA and PRGA; 2: reset at PRGA k=4
  task automatic run9(input logic [23:0] key, input int mode, output int cyc);
    do_clr();
    @(negedge clk); key9 = key; start9 = 1'b1;
    @(posedge clk); #1 start9 = 1'b0; key9 = ~key;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (done9) break;
      start9 = (mode == 1 && (cyc == 356 || cyc == 2330));
      if (mode == 2 && cyc == 2357) begin rst = 1'b1; break; end
    end
    start9 = 1'b0;
  endtask

  task automatic run32(input logic [23:0] key, output int cyc);
    do_clr();
    @(negedge clk); key32 = key; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0; key32 = ~key;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (done32) break;
    end
  endtask

  task automatic verify9_counts(input string tag, input int cyc);
    chk({tag, "_latency"}, cyc, 2413);
    chk({tag, "_busy_after_done"}, {31'd0, busy9}, 0);
    chk({tag, "_c_writes"}, cwr9, 9);
    chk({tag, "_c_addr_set"}, cmask9[31:0], 32'h1FF);
    chk({tag, "_c_addr_range"}, cbad9, 0);
    chk({tag, "_s_writes"}, swr9, 256 + 512 + 18);
    chk({tag, "_we_overlap"}, both9, 0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } cvec_t;

  cvec_t       tbl[9];
  logic [71:0] ptxt;
  logic [7:0]  exp_b;
  int          cyc, nmis;
  logic [255:0] seen;

  initial begin
    tbl[0] = '{8'd0, 8'hBB}; tbl[1] = '{8'd1, 8'hF3}; tbl[2] = '{8'd2, 8'h16};
    tbl[3] = '{8'd3, 8'hE8}; tbl[4] = '{8'd4, 8'hD9}; tbl[5] = '{8'd5, 8'h40};
    tbl[6] = '{8'd6, 8'hAF}; tbl[7] = '{8'd7, 8'h0A}; tbl[8] = '{8'd8, 8'hD3};
    ptxt = "Plaintext";
    for (int a = 0; a < 256; a++) begin
      p_mem9[a]  = (a < 9) ? ptxt[71 - 8*a -: 8] : 8'h00;
      p_mem32[a] = 8'h00;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy9", {31'd0, busy9}, 0);
    chk("rst_done9", {31'd0, done9}, 0);
    chk("rst_s_we9", {31'd0, s_we9}, 0);
    chk("rst_c_we9", {31'd0, c_we9}, 0);
    chk("rst_s_addr9", {24'd0, s_addr9}, 0);
    chk("rst_done32", {31'd0, done32}, 0);
    chk("rst_busy32", {31'd0, busy32}, 0);
    @(negedge clk); rst = 1'b0;

    // Test 1: known-answer vector
    run9(24'h4B6579, 0, cyc);
    for (int v = 0; v < 9; v++)
      chk($sformatf("t1_c[%0d]", tbl[v].addr), {24'd0, c_mem9[tbl[v].addr]}, {24'd0, tbl[v].exp});
    verify9_counts("t1", cyc);
    $display("t1 key=4B6579 latency=%0d", cyc);

    // Test 2: final S state and permutation property
    rc4_model(24'h4B6579, 9);
    nmis = 0; seen = '0;
    for (int a = 0; a < 256; a++) begin
      if (s_mem9[a] !== ref_s[a]) nmis++;
      seen[s_mem9[a]] = 1'b1;
    end
    chk("t2_s_final_mismatches", nmis, 0);
    chk("t2_perm_all_seen", {31'd0, &seen}, 1);
    $display("t2 S read-back mismatches=%0d", nmis);

    // Test 4: start pulses during KSA and PRGA are ignored
    run9(24'h4B6579, 1, cyc);
    for (int v = 0; v < 9; v++)
      chk($sformatf("t4_c[%0d]", tbl[v].addr), {24'd0, c_mem9[tbl[v].addr]}, {24'd0, tbl[v].exp});
    verify9_counts("t4", cyc);
    $display("t4 ignored starts latency=%0d", cyc);

    // Test 5: reset during PRGA k=4, then a clean run
    run9(24'hA5C3E1, 2, cyc);
    @(negedge clk);
    chk("t5_busy", {31'd0, busy9}, 0);
    chk("t5_done", {31'd0, done9}, 0);
    chk("t5_s_we", {31'd0, s_we9}, 0);
    chk("t5_c_we", {31'd0, c_we9}, 0);
    chk("t5_c_writes_before_abort", cwr9, 4);
    repeat (3) @(negedge clk);
    chk("t5_no_write_after_reset", cwr9, 4);
    rst = 1'b0;
    run9(24'hA5C3E1, 0, cyc);
    rc4_model(24'hA5C3E1, 9);
    for (int a = 0; a < 9; a++) begin
      exp_b = ref_ks[a] ^ p_mem9[a];
      chk($sformatf("t5_c[%0d]", a), {24'd0, c_mem9[a]}, {24'd0, exp_b});
    end
    verify9_counts("t5", cyc);
    $display("t5 restart after reset latency=%0d", cyc);

    // Test 3: zero key, zero plaintext, MSG_LEN=32, then decrypt back
    rc4_model(24'h000000, 32);
    run32(24'h000000, cyc);
    chk("t3_latency", cyc, 2689);
    for (int a = 0; a < 32; a++)
      chk($sformatf("t3_ks[%0d]", a), {24'd0, c_mem32[a]}, {24'd0, ref_ks[a]});
    chk("t3_c_writes", cwr32, 32);
    chk("t3_c_addr_set", cmask32[31:0], 32'hFFFF_FFFF);
    chk("t3_c_addr_range", cbad32, 0);
    chk("t3_s_writes", swr32, 256 + 512 + 64);
    chk("t3_we_overlap", both32, 0);
    $display("t3 keystream key=000000 latency=%0d", cyc);
    for (int a = 0; a < 32; a++) p_mem32[a] = c_mem32[a];
    run32(24'h000000, cyc);
    chk("t3b_latency", cyc, 2689);
    for (int a = 0; a < 32; a++)
      chk($sformatf("t3b_p[%0d]", a), {24'd0, c_mem32[a]}, 0);
    $display("t3b round-trip latency=%0d", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
